cloud_scroll_ctrl: RTL and testbench
====================================

Name: cloud_scroll_ctrl

Overview:
Frame-synchronous scheduler for the cloud background layer. Generates the horizontal scroll offset that the cloud address generator consumes, and sequences start, pause and recenter commands so the offset changes only at frame boundaries (no tearing). It sits between the game-state logic and the cloud address/RAM path. It takes the VGA frame pulse as its time base.

Parameters:
WIDTH_PX, 640, scroll period in screen pixels; cloud_offset wraps modulo this value.
RECENTER_STEP, 8, pixels advanced per frame while recentering.
SYNC_STAGES, 2, synchronizer depth on frame_clk (minimum 2).

Ports:
Clk  in  1  system clock.
Reset  in  1  asynchronous, active-high reset.
frame_clk  in  1  VGA frame pulse (vsync-derived), asynchronous to Clk.
start  in  1  single-cycle command: begin or resume scrolling.
pause  in  1  single-cycle command: freeze scrolling.
recenter  in  1  single-cycle command: return offset to 0, then idle.
speed  in  3  frames per step minus 1 (0 = step every frame, 7 = every 8th frame).
step  in  4  pixels added per step (0..15).
cloud_offset  out  10  current scroll offset, 0..WIDTH_PX-1.
frame_tick  out  1  one-cycle pulse per detected frame_clk rising edge.
state_o  out  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSED, 3 RECENTER.
busy  out  1  high in RUN or RECENTER.

Behaviour:
- Reset (async assert; release synchronous to Clk): cloud_offset=0, frame_tick=0, state IDLE, state_o=0, busy=0, frame divider=0, pending commands cleared, synchronizer flops cleared.
- frame_clk passes through SYNC_STAGES flops plus one edge register. frame_tick is high for exactly one Clk cycle per rising edge. Latency from the first Clk edge sampling frame_clk high to frame_tick high is SYNC_STAGES cycles.
- Commands are captured on any cycle into sticky pending bits. They are acted on only in the frame_tick cycle, and all pending bits clear on that cycle.
- If a command arrives in the same cycle as frame_tick, it is applied at that tick.
- Priority when several commands are pending: recenter > pause > start.
- State transitions, evaluated only in the frame_tick cycle:
  - IDLE: start -> RUN; recenter with offset!=0 -> RECENTER; pause is ignored.
  - RUN: recenter -> RECENTER; pause -> PAUSED; otherwise stay in RUN.
  - PAUSED: recenter -> RECENTER; start -> RUN; otherwise hold.
  - RECENTER: pause and start are ignored (their pending bits still clear). Go to IDLE once offset reaches 0.
- Frame divider (3-bit):
  - In RUN, on each tick: if divider==speed, apply a step and set divider to 0; else increment divider.
  - Outside RUN, divider is held at 0.
  - speed is sampled live on each tick. If speed is lowered below the current divider value, the compare fails and the divider wraps through 7 to 0 (documented; no special case).
- Step arithmetic:
  - Compute sum = offset + step in 11 bits.
  - If sum >= WIDTH_PX, new offset = sum - WIDTH_PX; else new offset = sum.
  - step=0 holds the offset while still consuming divider periods.
- RECENTER, on each tick:
  - sum = offset + RECENTER_STEP.
  - If sum >= WIDTH_PX or offset==0: offset=0 and state goes to IDLE on that same tick.
  - Otherwise offset=sum.
  - Recentering always travels forward, so the image never reverses.
- Timing of updates: cloud_offset and state_o update on the Clk edge that ends the frame_tick cycle, so new values are visible the cycle after frame_tick. cloud_offset is constant between ticks.
- A state entered on a tick takes effect on the next tick. Example: start applied at tick N gives the first step at tick N+1 when speed=0.
- Reset asserted mid-operation returns immediately to reset values. Any frame edge in flight during reset is dropped.

Decomposition:
- Shared package cloud_pkg holds:
  - state enum cloud_state_t (IDLE, RUN, PAUSED, RECENTER);
  - constants CLOUD_WIDTH_PX=640, CLOUD_ROW_PITCH=160, CLOUD_SCALE=4;
  - the 10-bit offset typedef.
- One natural sub-module: frame_edge_sync, the SYNC_STAGES synchronizer plus rising-edge detector producing frame_tick.

Test Plan:
- Reset/idle: assert Reset mid-cycle, release; drive 5 frame pulses with no commands -> cloud_offset=0, state_o=0, busy=0, exactly 5 single-cycle frame_tick pulses, each SYNC_STAGES cycles after the edge.
- Run, speed=0, step=4: start, then 10 ticks -> offset is 0 after the start tick, then 4, 8, ..., 36 on the following 9 ticks; value constant between ticks.
- Wrap and divider, speed=2, step=15, offset preloaded to 630 via run: on the next step tick (every 3rd tick) offset -> 5. The two intervening ticks hold 630.
- Priority: pulse start, pause and recenter in one cycle while in RUN at offset 600 -> RECENTER. Subsequent ticks give 608, 616, 624, 632, then 0 with state IDLE (busy falls in the same cycle).
- Pause/resume: in RUN at offset 100 (step 4), pause -> PAUSED; 4 ticks keep offset at 100; start -> RUN; next tick 104. Confirm pause in IDLE is ignored.
- Async reset during RECENTER at offset 320 -> immediate offset=0, state IDLE, no frame_tick for the first SYNC_STAGES cycles after release.

Source files
------------

// File: rtl/cloud_pkg.sv
// cloud_pkg: shared types and constants for the cloud background layer.
package cloud_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, RECENTER = 2'd3} cloud_state_t;
    typedef logic [9:0] cloud_offset_t;
    localparam int CLOUD_WIDTH_PX  = 640;
    localparam int CLOUD_ROW_PITCH = 160;
    localparam int CLOUD_SCALE     = 4;
endpackage

// File: rtl/frame_edge_sync.sv
// frame_edge_sync: synchronizes frame_clk into Clk and emits a one-cycle pulse per rising edge.
module frame_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);
    logic [SYNC_STAGES-1:0] sync;
    logic prev;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync       <= '0;
            prev       <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], frame_clk};
            prev       <= sync[SYNC_STAGES-1];
            frame_tick <= sync[SYNC_STAGES-1] & ~prev;
        end
    end
endmodule

// File: rtl/cloud_scroll_ctrl.sv
// cloud_scroll_ctrl: frame-synchronous scroll offset scheduler; commands only take effect on frame ticks.
module cloud_scroll_ctrl
    import cloud_pkg::*;
#(
    parameter int WIDTH_PX      = CLOUD_WIDTH_PX,
    parameter int RECENTER_STEP = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          frame_clk,
    input  logic          start,
    input  logic          pause,
    input  logic          recenter,
    input  logic [2:0]    speed,
    input  logic [3:0]    step,
    output cloud_offset_t cloud_offset,
    output logic          frame_tick,
    output logic [1:0]    state_o,
    output logic          busy
);
    localparam logic [10:0] W = 11'(WIDTH_PX);
    cloud_state_t  state, state_n;
    cloud_offset_t off_n;
    logic [2:0]    div, div_n;
    logic          p_start, p_pause, p_rec;
    logic          c_start, c_pause, c_rec;
    logic [10:0]   sum_step, sum_rc;

    frame_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .frame_tick(frame_tick)
    );

    // a command arriving in the tick cycle itself is honoured at that tick
    assign c_start  = p_start | start;
    assign c_pause  = p_pause | pause;
    assign c_rec    = p_rec | recenter;
    assign sum_step = {1'b0, cloud_offset} + {7'd0, step};
    assign sum_rc   = {1'b0, cloud_offset} + 11'(RECENTER_STEP);
    assign state_o  = state;
    assign busy     = (state == RUN) || (state == RECENTER);

    always_comb begin
        state_n = state;
        off_n   = cloud_offset;
        div_n   = frame_tick ? 3'd0 : div;
        if (frame_tick)
            case (state)
                IDLE:     state_n = c_rec ? (cloud_offset != '0 ? RECENTER : IDLE) : c_start ? RUN : IDLE;
                RUN:
                    if (c_rec) state_n = RECENTER;
                    else if (c_pause) state_n = PAUSED;
                    else if (div == speed) off_n = sum_step >= W ? 10'(sum_step - W) : sum_step[9:0];
                    else div_n = div + 3'd1;
                PAUSED:   state_n = c_rec ? RECENTER : c_start ? RUN : PAUSED;
                RECENTER: begin
                    state_n = (sum_rc >= W || cloud_offset == '0) ? IDLE : RECENTER;
                    off_n   = (sum_rc >= W || cloud_offset == '0) ? '0 : sum_rc[9:0];
                end
                default:  state_n = IDLE;
            endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            cloud_offset <= '0;
            div          <= '0;
            p_start      <= 1'b0;
            p_pause      <= 1'b0;
            p_rec        <= 1'b0;
        end else begin
            state        <= state_n;
            cloud_offset <= off_n;
            div          <= div_n;
            p_start      <= ~frame_tick & c_start;
            p_pause      <= ~frame_tick & c_pause;
            p_rec        <= ~frame_tick & c_rec;
        end
    end
endmodule

// File: tb/tb_cloud_scroll_ctrl.sv
// tb_cloud_scroll_ctrl: directed checks of tick timing, stepping, wrap, priority, pause and reset.
module tb_cloud_scroll_ctrl;
    logic       Clk = 0, Reset = 1, frame_clk = 0;
    logic       start = 0, pause = 0, recenter = 0;
    logic [2:0] speed = 0;
    logic [3:0] step = 0;
    logic [9:0] cloud_offset;
    logic       frame_tick, busy;
    logic [1:0] state_o;
    int         n_run = 0, n_fail = 0, tick_cnt = 0, base;

    cloud_scroll_ctrl dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start), .pause(pause),
        .recenter(recenter), .speed(speed), .step(step), .cloud_offset(cloud_offset),
        .frame_tick(frame_tick), .state_o(state_o), .busy(busy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) if (frame_tick) tick_cnt++;

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // frame pulse; optional commands driven during the tick cycle itself
    task automatic pulse(input logic s, input logic p, input logic r);
        @(negedge Clk) frame_clk = 1;
        @(negedge Clk);
        @(negedge Clk) chk("tick_early", frame_tick, 0);
        @(negedge Clk) chk("tick_lat", frame_tick, 1);
        frame_clk = 0; start = s; pause = p; recenter = r;
        @(negedge Clk) chk("tick_width", frame_tick, 0);
        start = 0; pause = 0; recenter = 0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic tk(input string tag, input int eo, input int es, input logic s, input logic p, input logic r);
        pulse(s, p, r);
        chk({tag, "_off"}, cloud_offset, eo);
        chk({tag, "_st"}, state_o, es);
    endtask

    initial begin
        repeat (2) @(negedge Clk);
        @(posedge Clk) #3 Reset = 1;
        #1 chk("rst_off", cloud_offset, 0);
        chk("rst_st", state_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tick", frame_tick, 0);
        @(negedge Clk) Reset = 0;
        base = tick_cnt;
        for (int i = 0; i < 5; i++) tk("idle", 0, 0, 0, 0, 0);
        chk("idle_ticks", tick_cnt - base, 5);
        chk("idle_busy", busy, 0);
        tk("idle_pause", 0, 0, 0, 1, 0);
        // start captured as a sticky pending bit well before the tick
        @(negedge Clk) start = 1;
        @(negedge Clk) start = 0;
        step = 4;
        tk("start", 0, 1, 0, 0, 0);
        chk("start_busy", busy, 1);
        for (int i = 1; i <= 25; i++) tk("run4", 4 * i, 1, 0, 0, 0);
        repeat (3) @(negedge Clk);
        chk("hold_between", cloud_offset, 100);
        tk("pause", 100, 2, 0, 1, 0);
        chk("pause_busy", busy, 0);
        for (int i = 0; i < 4; i++) tk("paused", 100, 2, 0, 0, 0);
        tk("resume", 100, 1, 1, 0, 0);
        tk("resume_step", 104, 1, 0, 0, 0);
        step = 8;
        for (int i = 1; i <= 62; i++) tk("run8", 104 + 8 * i, 1, 0, 0, 0);
        tk("prio", 600, 3, 1, 1, 1);
        chk("prio_busy", busy, 1);
        for (int i = 1; i <= 4; i++) tk("rc", 600 + 8 * i, 3, 1, 1, 0);
        tk("rc_done", 0, 0, 0, 0, 0);
        chk("rc_busy", busy, 0);
        step = 15;
        tk("start2", 0, 1, 1, 0, 0);
        for (int i = 1; i <= 42; i++) tk("run15", 15 * i, 1, 0, 0, 0);
        speed = 2;
        tk("div1", 630, 1, 0, 0, 0);
        tk("div2", 630, 1, 0, 0, 0);
        tk("wrap", 5, 1, 0, 0, 0);
        speed = 0; step = 5;
        for (int i = 1; i <= 63; i++) tk("run5", 5 + 5 * i, 1, 0, 0, 0);
        tk("rc320", 320, 3, 0, 0, 1);
        // frame edge in flight when reset hits must be dropped
        @(negedge Clk) frame_clk = 1;
        @(posedge Clk) #3 Reset = 1;
        #1 chk("arst_off", cloud_offset, 0);
        chk("arst_st", state_o, 0);
        chk("arst_busy", busy, 0);
        @(negedge Clk) frame_clk = 0;
        @(negedge Clk) Reset = 0;
        for (int i = 0; i < 5; i++) @(negedge Clk) chk("arst_notick", frame_tick, 0);
        tk("post_rst", 0, 0, 0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
